led_rgb_pwm: RTL and testbench
==============================

Name: led_rgb_pwm

Overview:
- Downstream stage for the ECPIX-5 on-board RGB LEDs. It sits between the LED colour source (control logic or free-running counter) and the four led_rgbN pin groups.
- Converts per-LED 8-bit R/G/B duty values into frame-synchronous PWM, so pin drive is dimmable and glitch-free.
- Double-buffers duty values. New colours take effect only at a PWM frame boundary.

Parameters:
- NLED, 4, number of RGB LEDs; fixed by the board, must be 4.
- DW, 8, duty/PWM counter width in bits; frame length is 2^DW ticks.
- PRESC, 64, fpga_sysclk cycles per PWM tick; must be ≥1.
- ACTIVE_LOW, 1, 1 = pin low lights the LED (board polarity); 0 = active-high.

Ports:
- fpga_sysclk  in  1  system clock; all logic is on the rising edge.
- rst_fpga_  in  1  reset; asynchronous assert, active-low.
- enable  in  1  1 = run PWM; 0 = all LEDs off, counters held.
- wr_valid  in  1  colour write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_led  in  2  target LED index, 0..3.
- wr_rgb  in  3*DW  duty values {R,G,B}; R in the MSBs.
- frame_start  out  1  one-cycle pulse, the cycle after a frame boundary.
- led_rgb0..led_rgb3  out  3 each  pin drive, bit2=R, bit1=G, bit0=B.

Behaviour:
- Reset is decided: rst_fpga_ is asynchronous, active-low; clock is fpga_sysclk.
- Reset values:
  - All led_rgbN are at the off level: 3'b111 if ACTIVE_LOW, else 3'b000.
  - frame_start=0; wr_ready=1.
  - Prescaler, pwm_cnt, pending and active duty registers are all 0.
- Prescaler: counts 0..PRESC-1. tick=1 when prescaler==PRESC-1 and enable=1. On tick the prescaler wraps to 0.
- pwm_cnt (DW bits): increments on tick. It wraps from 2^DW-1 to 0 with no extra cycle.
- enable=0:
  - Prescaler and pwm_cnt are cleared and held at 0.
  - Pins go to the off level on the next edge.
  - Writes are still accepted into pending.
- Frame boundary strobe, fb=1 in either case:
  - enable & tick & pwm_cnt==2^DW-1, or
  - the first cycle enable is seen high after being low (enable rising edge, registered detect).
- On fb all 12 pending duty values are copied to active in the same cycle.
- Write handshake:
  - wr_ready = ~fb, combinational from registered state.
  - On accept, pending[wr_led] <= wr_rgb.
  - When fb=1, wr_valid must be held. It completes on the next cycle, so the copy never races the write.
  - Back-to-back writes are accepted one per cycle outside fb.
  - Multiple writes to the same LED within a frame: the last one wins.
- Channel compare: on = (pwm_cnt < active_duty), unsigned DW-bit compare.
  - duty=0: never on.
  - duty=2^DW-1: on for 2^DW-1 of 2^DW ticks. 100% is not reachable, by design.
- Pin output: registered. pin = ACTIVE_LOW ? ~on : on, forced to the off level when enable=0. Latency is 1 cycle from pwm_cnt/active change to pin.
- frame_start = fb delayed one cycle. In that cycle pwm_cnt==0 and the new active values are in use.
- Reset mid-frame: all state returns to reset values immediately (async). No partial copy is retained.
- A write with wr_led out of range cannot occur (2-bit index, NLED=4).

Test Plan:
- Reset: hold rst_fpga_=0 with enable=1 -> all led_rgbN=3'b111, wr_ready=1, frame_start=0; release -> pins remain 3'b111 (active duty 0).
- Duty measure: PRESC=4, enable=1, write LED0={8'd64,8'd0,8'd255} -> from the next frame_start, each 1024-cycle frame has led_rgb0[2] low for exactly 256 cycles, [1] never low, [0] low 1020 cycles.
- Frame-synchronous update: write LED1 R=200 mid-frame -> led_rgb1 unchanged until the cycle after frame_start; first frame after it shows R low 800 cycles.
- Boundary collision: assert wr_valid exactly on the fb cycle -> wr_ready=0 that cycle, write accepted the next cycle, value appears one frame later, not in the current frame.
- Enable gating: drop enable mid-frame -> pins 3'b111 next cycle, pwm_cnt=0; write LED3 while disabled; raise enable -> fb on the first enabled cycle, frame_start one cycle later, LED3 runs with the new duty immediately.
- Last-write-wins: three writes to LED2 in one frame (10, 20, 30) -> the next frame shows R low for 120 cycles (PRESC=4).

Source files
------------

// File: rtl/led_rgb_pwm_if.sv
// ============================================================================
// led_rgb_pwm_if : colour-write channel (valid/ready) for led_rgb_pwm. Rev 1.0
// ============================================================================
`default_nettype none

interface led_rgb_pwm_if #(
    parameter int NLED = 4,
    parameter int DW   = 8
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [$clog2(NLED)-1:0] wr_led;
    logic [3*DW-1:0]         wr_rgb;

    modport master (output wr_valid, output wr_led, output wr_rgb, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_led, input  wr_rgb, output wr_ready);
endinterface

`default_nettype wire

// File: rtl/led_rgb_pwm.sv
// ============================================================================
// led_rgb_pwm : frame-synchronous, double-buffered PWM for the four ECPIX-5 RGB LEDs. Rev 1.0
// ============================================================================
`default_nettype none

module led_rgb_pwm #(
    parameter int NLED       = 4,
    parameter int DW         = 8,
    parameter int PRESC      = 64,
    parameter int ACTIVE_LOW = 1
) (
    input  wire logic       fpga_sysclk,
    input  wire logic       rst_fpga_,
    input  wire logic       enable,
    led_rgb_pwm_if.slave    wr,
    output logic            frame_start,
    output logic [2:0]      led_rgb0,
    output logic [2:0]      led_rgb1,
    output logic [2:0]      led_rgb2,
    output logic [2:0]      led_rgb3
);

    localparam int         PW        = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC - 1);
    localparam logic [2:0] PIN_OFF   = (ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

    logic [PW-1:0]   presc;
    logic [DW-1:0]   pwm_cnt;
    logic            en_d;
    logic [3*DW-1:0] pending [NLED];
    logic [3*DW-1:0] active  [NLED];
    logic [2:0]      pins    [NLED];
    logic [2:0]      on      [NLED];
    logic            tick;
    logic            fb;
    logic            accept;

    assign tick = enable & (presc == PRESC_MAX);

    // Gated by reset so the port reads ready while held in reset, even with enable high.
    assign fb     = rst_fpga_ & enable & (~en_d | (tick & (pwm_cnt == '1)));
    assign accept = wr.wr_valid & wr.wr_ready;
    assign wr.wr_ready = ~fb;

    for (genvar i = 0; i < NLED; i++) begin : g_led
        for (genvar c = 0; c < 3; c++) begin : g_ch
            assign on[i][c] = pwm_cnt < active[i][c*DW +: DW];
        end
    end

    always_ff @(posedge fpga_sysclk or negedge rst_fpga_) begin
        if (!rst_fpga_) begin
            presc       <= '0;
            pwm_cnt     <= '0;
            en_d        <= 1'b0;
            frame_start <= 1'b0;
            for (int i = 0; i < NLED; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
                pins[i]    <= PIN_OFF;
            end
        end else begin
            en_d        <= enable;
            frame_start <= fb;

            // The first enabled cycle is itself a frame start, so counting begins one cycle later.
            if (!enable || !en_d) begin
                presc   <= '0;
                pwm_cnt <= '0;
            end else if (tick) begin
                presc   <= '0;
                pwm_cnt <= pwm_cnt + 1'b1;
            end else begin
                presc   <= presc + 1'b1;
            end

            for (int i = 0; i < NLED; i++) begin
                if (fb) begin
                    active[i] <= pending[i];
                end
                if (!enable) begin
                    pins[i] <= PIN_OFF;
                end else begin
                    pins[i] <= (ACTIVE_LOW != 0) ? ~on[i] : on[i];
                end
            end

            if (accept) begin
                pending[wr.wr_led] <= wr.wr_rgb;
            end
        end
    end

    assign led_rgb0 = pins[0];
    assign led_rgb1 = pins[1];
    assign led_rgb2 = pins[2];
    assign led_rgb3 = pins[3];

endmodule

`default_nettype wire

// File: tb/tb_led_rgb_pwm.sv
// Bench for led_rgb_pwm: random colour writes checked against a frame-level duty model.
`timescale 1ns/1ps
`default_nettype none

module tb_led_rgb_pwm;
    localparam int DW    = 8;
    localparam int NLED  = 4;
    localparam int PRESC = 4;
    localparam int FRAME = PRESC * (1 << DW);

    logic       fpga_sysclk = 1'b0;
    logic       rst_fpga_   = 1'b0;
    logic       enable      = 1'b1;
    logic       frame_start;
    logic [2:0] led_rgb0, led_rgb1, led_rgb2, led_rgb3;

    led_rgb_pwm_if #(.NLED(NLED), .DW(DW)) wr_if ();

    led_rgb_pwm #(.NLED(NLED), .DW(DW), .PRESC(PRESC), .ACTIVE_LOW(1)) dut (
        .fpga_sysclk (fpga_sysclk),
        .rst_fpga_   (rst_fpga_),
        .enable      (enable),
        .wr          (wr_if),
        .frame_start (frame_start),
        .led_rgb0    (led_rgb0),
        .led_rgb1    (led_rgb1),
        .led_rgb2    (led_rgb2),
        .led_rgb3    (led_rgb3)
    );

    always #5 fpga_sysclk = ~fpga_sysclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: frames start every FRAME cycles from the cycle after enable (or reset release) is seen.
    int cyc  = 0;
    int base = 0;
    bit en_m = 1'b0;
    int pending_m [4][3];
    int active_m  [4][3];

    function automatic bit is_fs(input int c);
        return en_m && (c >= base) && (((c - base) % FRAME) == 0);
    endfunction

    always @(posedge fpga_sysclk) begin
        cyc <= cyc + 1;
        if (!rst_fpga_) begin
            for (int i = 0; i < 4; i++)
                for (int c = 0; c < 3; c++) active_m[i][c] <= 0;
        end else if (is_fs(cyc + 1)) begin
            for (int i = 0; i < 4; i++)
                for (int c = 0; c < 3; c++) active_m[i][c] <= pending_m[i][c];
        end
    end

    function automatic logic [2:0] pin_of(input int i);
        case (i)
            0:       return led_rgb0;
            1:       return led_rgb1;
            2:       return led_rgb2;
            default: return led_rgb3;
        endcase
    endfunction

    // Stimulus/measurement utilities (no checks inside).
    int lows [4][3];
    int snap [4][3];
    bit fs_seen;
    bit tmo;
    int trk_err;

    task automatic write_led(input int led, input int r, input int g, input int b);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_led   = 2'(led);
        wr_if.wr_rgb   = {8'(r), 8'(g), 8'(b)};
        for (int k = 0; k < 4; k++) begin
            if (!is_fs(cyc + 1)) begin
                @(posedge fpga_sysclk);
                pending_m[led][2] = r;
                pending_m[led][1] = g;
                pending_m[led][0] = b;
                @(negedge fpga_sysclk);
                break;
            end
            @(negedge fpga_sysclk);
        end
    endtask

    task automatic release_wr();
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic measure_frame();
        logic [2:0] p;
        int w = 0;
        while (!is_fs(cyc) && w < 2 * FRAME) begin
            @(negedge fpga_sysclk);
            w++;
        end
        tmo     = !is_fs(cyc);
        fs_seen = frame_start;
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 3; c++) begin
                snap[i][c] = active_m[i][c];
                lows[i][c] = 0;
            end
        repeat (FRAME) begin
            @(negedge fpga_sysclk);
            for (int i = 0; i < 4; i++) begin
                p = pin_of(i);
                for (int c = 0; c < 3; c++) if (p[c] == 1'b0) lows[i][c]++;
            end
        end
    endtask

    // Pins of one LED against the currently active model duties until the next frame boundary.
    task automatic track_led(input int led);
        int n = 0;
        int pwm;
        logic [2:0] exp_p;
        trk_err = 0;
        while (!is_fs(cyc) && n < FRAME + 8) begin
            pwm = ((cyc - 1 - base) % FRAME) / PRESC;
            for (int c = 0; c < 3; c++) exp_p[c] = (pwm < active_m[led][c]) ? 1'b0 : 1'b1;
            if (pin_of(led) !== exp_p) trk_err++;
            @(negedge fpga_sysclk);
            n++;
        end
    endtask

    task automatic test_reset();
        int errs = 0;
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < 3; c++) pending_m[i][c] = 0;
        rst_fpga_ = 1'b0;
        enable    = 1'b1;
        en_m      = 1'b0;
        repeat (3) @(negedge fpga_sysclk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (pin_of(i) !== 3'b111) begin
                n_fail++;
                $display("FAIL reset_pin%0d: got %b expected 111", i, pin_of(i));
            end
        end
        n_checks++;
        if (wr_if.wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wr_ready: got %b expected 1", wr_if.wr_ready);
        end
        n_checks++;
        if (frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_frame_start: got %b expected 0", frame_start);
        end
        rst_fpga_ = 1'b1;
        en_m      = 1'b1;
        base      = cyc + 1;
        @(negedge fpga_sysclk);
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_frame_start: got %b expected 1", frame_start);
        end
        repeat (40) begin
            @(negedge fpga_sysclk);
            for (int i = 0; i < 4; i++) if (pin_of(i) !== 3'b111) errs++;
        end
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL reset_pins_stay_off: got %0d lit samples expected 0", errs);
        end
    endtask

    task automatic test_duty();
        write_led(0, 64, 0, 255);
        release_wr();
        measure_frame();
        n_checks++;
        if (tmo || !fs_seen) begin
            n_fail++;
            $display("FAIL duty_frame_start: got fs=%b timeout=%b expected fs=1 timeout=0", fs_seen, tmo);
        end
        n_checks++;
        if (lows[0][2] != 256 || lows[0][1] != 0 || lows[0][0] != 1020) begin
            n_fail++;
            $display("FAIL duty_led0: got R=%0d G=%0d B=%0d expected 256 0 1020",
                     lows[0][2], lows[0][1], lows[0][0]);
        end
        for (int i = 1; i < 4; i++)
            for (int c = 0; c < 3; c++) begin
                n_checks++;
                if (lows[i][c] != snap[i][c] * PRESC) begin
                    n_fail++;
                    $display("FAIL duty_led%0d_ch%0d: got %0d expected %0d", i, c, lows[i][c], snap[i][c] * PRESC);
                end
            end
    endtask

    task automatic test_frame_sync();
        int w = 0;
        int g = $urandom_range(0, 255);
        int b = $urandom_range(0, 255);
        while (((cyc - base) % FRAME) != 500 && w < 2 * FRAME) begin
            @(negedge fpga_sysclk);
            w++;
        end
        write_led(1, 200, g, b);
        release_wr();
        track_led(1);
        n_checks++;
        if (trk_err != 0) begin
            n_fail++;
            $display("FAIL frame_sync_no_early_update: got %0d bad samples expected 0", trk_err);
        end
        measure_frame();
        n_checks++;
        if (lows[1][2] != 800) begin
            n_fail++;
            $display("FAIL frame_sync_led1_R: got %0d expected 800", lows[1][2]);
        end
        n_checks++;
        if (lows[1][1] != g * PRESC || lows[1][0] != b * PRESC) begin
            n_fail++;
            $display("FAIL frame_sync_led1_GB: got %0d %0d expected %0d %0d", lows[1][1], lows[1][0], g * PRESC, b * PRESC);
        end
    endtask

    task automatic test_collision();
        int w = 0;
        int r = (active_m[2][2] < 128) ? 200 : 50;
        int g = $urandom_range(0, 255);
        int b = $urandom_range(0, 255);
        while (!is_fs(cyc + 1) && w < 2 * FRAME) begin
            @(negedge fpga_sysclk);
            w++;
        end
        wr_if.wr_valid = 1'b1;
        wr_if.wr_led   = 2'd2;
        wr_if.wr_rgb   = {8'(r), 8'(g), 8'(b)};
        n_checks++;
        if (wr_if.wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_ready_on_fb: got %b expected 0", wr_if.wr_ready);
        end
        @(posedge fpga_sysclk);
        @(negedge fpga_sysclk);
        n_checks++;
        if (frame_start !== 1'b1 || wr_if.wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_next_cycle: got fs=%b ready=%b expected 1 1", frame_start, wr_if.wr_ready);
        end
        @(posedge fpga_sysclk);
        pending_m[2][2] = r;
        pending_m[2][1] = g;
        pending_m[2][0] = b;
        @(negedge fpga_sysclk);
        release_wr();
        track_led(2);
        n_checks++;
        if (trk_err != 0) begin
            n_fail++;
            $display("FAIL collision_not_in_current_frame: got %0d bad samples expected 0", trk_err);
        end
        measure_frame();
        n_checks++;
        if (lows[2][2] != r * PRESC || lows[2][1] != g * PRESC || lows[2][0] != b * PRESC) begin
            n_fail++;
            $display("FAIL collision_next_frame: got %0d %0d %0d expected %0d %0d %0d",
                     lows[2][2], lows[2][1], lows[2][0], r * PRESC, g * PRESC, b * PRESC);
        end
    endtask

    task automatic test_last_write();
        write_led(2, 10, 5, 6);
        write_led(2, 20, 7, 8);
        write_led(2, 30, 9, 11);
        release_wr();
        measure_frame();
        n_checks++;
        if (lows[2][2] != 120) begin
            n_fail++;
            $display("FAIL last_write_R: got %0d expected 120", lows[2][2]);
        end
        n_checks++;
        if (lows[2][1] != snap[2][1] * PRESC || lows[2][0] != snap[2][0] * PRESC) begin
            n_fail++;
            $display("FAIL last_write_GB: got %0d %0d expected %0d %0d", lows[2][1], lows[2][0],
                     snap[2][1] * PRESC, snap[2][0] * PRESC);
        end
    endtask

    task automatic test_enable();
        int errs = 0;
        int r = $urandom_range(1, 255);
        int g = $urandom_range(1, 255);
        int b = $urandom_range(1, 255);
        repeat (300) @(negedge fpga_sysclk);
        enable = 1'b0;
        en_m   = 1'b0;
        @(negedge fpga_sysclk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (pin_of(i) !== 3'b111) begin
                n_fail++;
                $display("FAIL enable_off_pin%0d: got %b expected 111", i, pin_of(i));
            end
        end
        write_led(3, r, g, b);
        release_wr();
        n_checks++;
        if (wr_if.wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_off_ready: got %b expected 1", wr_if.wr_ready);
        end
        repeat (20) begin
            @(negedge fpga_sysclk);
            for (int i = 0; i < 4; i++) if (pin_of(i) !== 3'b111) errs++;
        end
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL enable_off_hold: got %0d lit samples expected 0", errs);
        end
        enable = 1'b1;
        en_m   = 1'b1;
        base   = cyc + 1;
        #1;
        n_checks++;
        if (wr_if.wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_rise_fb: got ready=%b expected 0", wr_if.wr_ready);
        end
        @(negedge fpga_sysclk);
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_rise_frame_start: got %b expected 1", frame_start);
        end
        measure_frame();
        n_checks++;
        if (lows[3][2] != r * PRESC || lows[3][1] != g * PRESC || lows[3][0] != b * PRESC) begin
            n_fail++;
            $display("FAIL enable_led3_new_duty: got %0d %0d %0d expected %0d %0d %0d",
                     lows[3][2], lows[3][1], lows[3][0], r * PRESC, g * PRESC, b * PRESC);
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 3; round++) begin
            int n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++)
                write_led($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            release_wr();
            measure_frame();
            for (int i = 0; i < 4; i++)
                for (int c = 0; c < 3; c++) begin
                    n_checks++;
                    if (lows[i][c] != snap[i][c] * PRESC) begin
                        n_fail++;
                        $display("FAIL random%0d_led%0d_ch%0d: got %0d expected %0d", round, i, c,
                                 lows[i][c], snap[i][c] * PRESC);
                    end
                end
        end
    endtask

    initial begin
        wr_if.wr_valid = 1'b0;
        wr_if.wr_led   = '0;
        wr_if.wr_rgb   = '0;
        test_reset();
        test_duty();
        test_frame_sync();
        test_collision();
        test_last_write();
        test_enable();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
